// File: rtl/cpu_types_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
//   WORD_W   : datapath width
//   MD_ITER  : iterations per multiply/divide
//   ACC_W    : {carry|rem_msb, hi/rem, lo/quot} working register width
//   mdop_t   : multiply/divide opcode
//   md_state_t : md_unit FSM states
//   abs_w()  : two's-complement magnitude (0x8000_0000 maps to itself)
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int MD_ITER = 32;
  localparam int ACC_W   = 2 * WORD_W + 1;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

  function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/md_if.sv
// Signal bundle for md_unit.
//   modport md : the unit side (drives busy/done/divzero/hi/lo)
//   modport tb : the requester side (drives start/mdop/operands/mthi/mtlo)
interface md_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic              RST;
  logic              start;
  mdop_t             mdop;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic              mthi;
  logic              mtlo;
  logic [WORD_W-1:0] wdat;
  logic              busy;
  logic              done;
  logic              divzero;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

  modport md (
    input  CLK, RST, start, mdop, port_a, port_b, mthi, mtlo, wdat,
    output busy, done, divzero, hi, lo
  );

  modport tb (
    input  CLK, busy, done, divzero, hi, lo,
    output RST, start, mdop, port_a, port_b, mthi, mtlo, wdat
  );
endinterface

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc     : multiply {carry, acc_hi, acc_lo} / divide {rem[32:0], quot}
//   opnd    : multiplicand (multiply) or divisor (divide)
//   acc_nxt : next working register; in divide mode quot[0] is left 0
//   qbit    : quotient bit for this step (divide only, 0 in multiply)
module md_step
  import cpu_types_pkg::*;
(
  input  logic              is_div,
  input  logic [ACC_W-1:0]  acc,
  input  logic [WORD_W-1:0] opnd,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic              qbit
);

  logic [WORD_W:0]   mul_sum;
  logic [WORD_W:0]   rem_sh;
  logic [WORD_W-1:0] quot_sh;
  logic [WORD_W+1:0] diff;

  always_comb begin
    mul_sum = acc[ACC_W-1:WORD_W] + {1'b0, (acc[0] ? opnd : '0)};

    // The remainder is always below the divisor, so its MSB is zero before
    // the shift and nothing is lost off the top.
    rem_sh  = {acc[2*WORD_W-1:WORD_W], acc[WORD_W-1]};
    quot_sh = {acc[WORD_W-2:0], 1'b0};
    diff    = {1'b0, rem_sh} - {2'b00, opnd};

    acc_nxt = '0;
    qbit    = 1'b0;
    if (is_div) begin
      qbit = ~diff[WORD_W+1];
      if (qbit) acc_nxt = {diff[WORD_W:0], quot_sh};
      else      acc_nxt = {rem_sh, quot_sh};
    end else begin
      acc_nxt = {1'b0, mul_sum, acc[WORD_W-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing architectural HI/LO.
//   CLK, RST        : clock, asynchronous active-high reset
//   start, mdop     : launch an operation (sampled in IDLE only)
//   port_a, port_b  : rs / rt operands
//   mthi, mtlo, wdat: direct HI/LO writes, IDLE and start = 0 only
//   busy            : state != IDLE
//   done, divzero   : one-cycle pulses when HI/LO take a new result
//   hi, lo          : architectural HI/LO
//
// state | meaning
// IDLE  | waiting for start; accepts mthi/mtlo
// RUN   | MD_ITER shift-add / restoring-divide iterations
// FIX   | sign correction, HI/LO write, done pulse
module md_unit
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  mdop_t             mdop,
  input  logic [WORD_W-1:0] port_a,
  input  logic [WORD_W-1:0] port_b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [WORD_W-1:0] wdat,
  output logic              busy,
  output logic              done,
  output logic              divzero,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  md_state_t         state_q, state_d;
  logic [5:0]        count_q;
  mdop_t             op_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              dz_q;
  logic [WORD_W-1:0] a_raw_q;
  logic [WORD_W-1:0] opnd_q;
  logic [ACC_W-1:0]  acc_q;
  logic [WORD_W-1:0] hi_q, lo_q;
  logic              done_q, divzero_q;

  logic              in_signed, in_div, op_div;
  logic [WORD_W-1:0] mag_a, mag_b;
  logic [ACC_W-1:0]  step_acc;
  logic              step_q;
  logic [2*WORD_W-1:0] prod;
  logic [WORD_W-1:0] quot, rem;
  logic [WORD_W-1:0] res_hi, res_lo;

  always_comb begin
    in_signed = (mdop == MD_MULT) || (mdop == MD_DIV);
    in_div    = (mdop == MD_DIV)  || (mdop == MD_DIVU);
    mag_a     = in_signed ? abs_w(port_a) : port_a;
    mag_b     = in_signed ? abs_w(port_b) : port_b;
    op_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  end

  md_step u_step (
    .is_div  (op_div),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .qbit    (step_q)
  );

  // Sign fix-up; the flags are zero for unsigned ops so this is a pass-through.
  always_comb begin
    prod   = neg_res_q ? -acc_q[2*WORD_W-1:0] : acc_q[2*WORD_W-1:0];
    quot   = neg_res_q ? -acc_q[WORD_W-1:0] : acc_q[WORD_W-1:0];
    rem    = neg_rem_q ? -acc_q[2*WORD_W-1:WORD_W] : acc_q[2*WORD_W-1:WORD_W];
    res_hi = prod[2*WORD_W-1:WORD_W];
    res_lo = prod[WORD_W-1:0];
    if (op_div) begin
      if (dz_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == 6'(MD_ITER - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q   <= '0;
      op_q      <= MD_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q      <= mdop;
            neg_res_q <= in_signed & (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
            neg_rem_q <= in_signed & port_a[WORD_W-1];
            dz_q      <= in_div & (port_b == '0);
            a_raw_q   <= port_a;
            count_q   <= '0;
            // Multiply iterates over the multiplier in acc_lo; divide shifts
            // the dividend out of the quotient field. Both start with the
            // upper accumulator cleared.
            acc_q     <= {{(WORD_W+1){1'b0}}, (in_div ? mag_a : mag_b)};
            opnd_q    <= in_div ? mag_b : mag_a;
          end else begin
            if (mthi) hi_q <= wdat;
            if (mtlo) lo_q <= wdat;
          end
        end
        S_RUN: begin
          acc_q   <= op_div ? {step_acc[ACC_W-1:1], step_q} : step_acc;
          count_q <= count_q + 6'd1;
        end
        S_FIX: begin
          hi_q      <= res_hi;
          lo_q      <= res_lo;
          done_q    <= 1'b1;
          divzero_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO/divzero are queued when an
// operation is issued and compared when done pulses.
module tb_md_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  md_if mif (.CLK(CLK));

  md_unit dut (
    .CLK     (mif.CLK),
    .RST     (mif.RST),
    .start   (mif.start),
    .mdop    (mif.mdop),
    .port_a  (mif.port_a),
    .port_b  (mif.port_b),
    .mthi    (mif.mthi),
    .mtlo    (mif.mtlo),
    .wdat    (mif.wdat),
    .busy    (mif.busy),
    .done    (mif.done),
    .divzero (mif.divzero),
    .hi      (mif.hi),
    .lo      (mif.lo)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb_i;
    e  = '0;
    sa = a;
    sb_i = b;
    case (op)
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
      default: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.hi = 0; e.lo = a; end
        else begin e.hi = 32'(sa % sb_i); e.lo = 32'(sa / sb_i); end
      end
    endcase
    return e;
  endfunction

  // Scoreboard consumer.
  always @(negedge CLK) begin
    if (!mif.RST && mif.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", mif.done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_hi", mif.hi, e.hi);
        chk("res_lo", mif.lo, e.lo);
        chk("res_divzero", mif.divzero, e.dz);
      end
    end
    if (!mif.RST && mif.divzero && !mif.done) chk("divzero_without_done", mif.divzero, 0);
  end

  always @(posedge CLK) begin
    if (!mif.RST && mif.busy)
      assert (!(mif.mthi || mif.mtlo)) else $error("mthi/mtlo driven while busy");
  end

  task automatic wait_idle();
    int n = 0;
    while (mif.busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (mif.busy) chk("idle_timeout", mif.busy, 0);
  endtask

  task automatic issue(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input logic with_mthi);
    exp_t e;
    @(negedge CLK);
    wait_idle();
    mif.start  = 1'b1;
    mif.mdop   = op;
    mif.port_a = a;
    mif.port_b = b;
    mif.mthi   = with_mthi;
    mif.wdat   = 32'hDEAD_BEEF;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    mif.start = 1'b0;
    mif.mthi  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int          n, busy_n;
    logic        moved;
    logic [31:0] hold_hi, hold_lo;
    exp_t        e;

    mif.RST = 1'b1; mif.start = 0; mif.mdop = MD_MULT;
    mif.port_a = 0; mif.port_b = 0; mif.mthi = 0; mif.mtlo = 0; mif.wdat = 0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_divzero", mif.divzero, 0);
    chk("rst_hi", mif.hi, 0);
    chk("rst_lo", mif.lo, 0);
    mif.RST = 1'b0;

    // MULTU with latency / busy-width / HI-LO hold checks.
    hold_hi = mif.hi; hold_lo = mif.lo;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    n = 0; busy_n = 0; moved = 0;
    while (n < 60) begin
      @(negedge CLK);
      n++;
      if (mif.busy) busy_n++;
      if (mif.done) break;
      if (mif.hi !== hold_hi || mif.lo !== hold_lo) moved = 1;
    end
    chk("done_latency", n, 34);
    chk("busy_cycles", busy_n, 33);
    chk("hilo_hold_in_run", moved, 0);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    issue(MD_MULT, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 0, 0);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0);
    issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    issue(MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);
    issue(MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 0, 0);
    drain();

    // start during RUN is ignored.
    issue(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0, 0);
    repeat (5) @(negedge CLK);
    mif.start = 1; mif.mdop = MD_DIVU; mif.port_a = 32'd1000; mif.port_b = 32'd3;
    @(negedge CLK);
    mif.start = 0;
    chk("run_start_hi", mif.hi, 32'd0);
    chk("run_start_lo", mif.lo, 32'd3);
    drain();
    repeat (40) @(negedge CLK);
    chk("run_start_no_op", mif.busy, 0);

    // Direct HI/LO writes.
    mif.mthi = 1; mif.wdat = 32'h0000_1234;
    @(negedge CLK);
    mif.mthi = 0;
    chk("mthi_hi", mif.hi, 32'h0000_1234);
    chk("mthi_lo_kept", mif.lo, 32'd15);
    mif.mthi = 1; mif.mtlo = 1; mif.wdat = 32'h0000_ABCD;
    @(negedge CLK);
    mif.mthi = 0; mif.mtlo = 0;
    chk("mthilo_hi", mif.hi, 32'h0000_ABCD);
    chk("mthilo_lo", mif.lo, 32'h0000_ABCD);

    // mthi together with start: start wins.
    issue(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0, 1);
    chk("mthi_dropped", mif.hi, 32'h0000_ABCD);
    drain();

    for (int i = 0; i < 8; i++) begin
      mdop_t       op;
      logic [31:0] a, b;
      op = mdop_t'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i < 2) b = b & 32'h0000_00FF;
      e = model(op, a, b);
      issue(op, a, b, e.hi, e.lo, e.dz, 0);
    end
    drain();

    // Asynchronous reset mid-RUN.
    issue(MD_MULTU, 32'd11, 32'd13, 32'd0, 32'd143, 0, 0);
    repeat (10) @(posedge CLK);
    #2;
    mif.RST = 1'b1;
    #1;
    chk("arst_busy", mif.busy, 0);
    chk("arst_hi", mif.hi, 0);
    chk("arst_lo", mif.lo, 0);
    chk("arst_done", mif.done, 0);
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    mif.RST = 1'b0;
    chk("arst_done_after", mif.done, 0);
    issue(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
    drain();
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the execute stage. It sits beside the ALU and takes the same rs/rt operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers. The stage result mux reads HI/LO for MFHI/MFLO, and hazard logic stalls the pipeline on `busy`.

## Interface
- No parameters. Width is `WORD_W` (32) from `cpu_types_pkg`. Iteration count is `MD_ITER` (32) from `cpu_types_pkg`.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: reset. One clock; reset is asynchronous and active-high.
- `start` in 1: launch operation (sampled only in IDLE).
- `mdop` in 2: `mdop_t` (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`).
- `port_a` in 32: rs operand (multiplicand / dividend).
- `port_b` in 32: rt operand (multiplier / divisor).
- `mthi`, `mtlo` in 1: direct write of HI / LO from `wdat`.
- `wdat` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress; the pipeline stalls while high.
- `done` out 1: single-cycle pulse when HI/LO take a new result.
- `divzero` out 1: pulses with `done` when a DIV/DIVU had `port_b == 0`.
- `hi`, `lo` out 32: architectural HI/LO registers.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE → RUN** on `start`:
  - latch `mdop`;
  - for signed ops, latch |port_a|, |port_b| and the sign flags;
  - unsigned ops take the raw operands;
  - clear `count` (6 bits) and the accumulators.
- **RUN, multiply:** radix-2 shift-add on a 65-bit {carry, acc_hi, acc_lo}. acc_lo starts with the multiplier. Each iteration:
  - if acc_lo[0] = 1, add the multiplicand into acc_hi;
  - shift the whole register right by 1.
- **RUN, divide:** restoring division. The 33-bit remainder starts at 0 and the quotient register starts with the dividend. Each iteration:
  - shift {rem, quot} left by 1;
  - subtract the divisor from rem;
  - if non-negative, keep the difference and set quot[0] = 1;
  - otherwise restore rem.
- RUN executes exactly `MD_ITER` iterations, count 0..31. RUN → FIX when count = 31.
- **FIX:** apply sign correction and write HI/LO, then return to IDLE.
  - Signed multiply: negate the 64-bit product if the sign flags differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Multiply writes HI = upper 32 bits, LO = lower 32 bits.
  - Divide writes LO = quotient, HI = remainder.
- **Divide by zero:** full latency still runs. FIX writes HI = original `port_a`, LO = 32'hFFFF_FFFF, and `divzero` pulses.
- **Signed 0x8000_0000 / 0xFFFF_FFFF:** LO = 0x8000_0000, HI = 0. This falls out of magnitude arithmetic; no special case.
- **MTHI/MTLO:** accepted only in IDLE when `start` = 0. They write HI/LO at the next edge.
  - `mthi` and `mtlo` may both be high; each register is written.
  - If `start` is also high, `start` wins and the writes are dropped.
  - While busy, `mthi`/`mtlo` are ignored. The bench asserts this never happens.
- `start` while busy is ignored.

## Timing
- **Reset:** asynchronous, active-high. Forces IDLE, `count` = 0, `hi` = `lo` = 0, `busy` = `done` = `divzero` = 0. Applies mid-operation; the in-flight operation is discarded.
- Edge E0 samples `start` in IDLE. Iterations happen on edges E1..E32. Edge E33 performs FIX and writes HI/LO.
- `busy` = (state != IDLE): high from after E0 until E33 (33 cycles).
- `done` and `divzero` are registered. They are high for the single cycle after E33.
- The new `hi`/`lo` are visible in the same cycle as `done`.
- A new `start` may be accepted at E33 + 1, the cycle `done` is high. Back-to-back issue is therefore 34 cycles.
- `hi`/`lo` hold their old values throughout RUN. No partial result is ever visible.
- All outputs are driven directly from registers. There are no combinational paths from inputs to outputs.

## Structure
- `mdop_t` (2-bit enum) and `MD_ITER` go in `cpu_types_pkg`.
- Signals are bundled in `md_if` with two modports: `md` for the unit and `tb` for the bench, matching the ALU interface style.
- One combinational sub-module, `md_step`, implements a single iteration. It takes mode, accumulator and operand, and returns the next accumulator plus the quotient bit.
- The FSM, counter, sign handling and HI/LO registers stay in `md_unit`.

## Test plan
- **MULTU:** 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001. `done` is seen exactly 34 cycles after the start edge; `busy` is high for 33 cycles.
- **MULT:** −3 (0xFFFF_FFFD) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB. Also 0 × 0x8000_0000 → HI = LO = 0.
- **DIV:**
  - −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
  - DIVU 100 / 7 → LO = 14, HI = 2.
- **Divide by zero:** DIV 5 / 0 → HI = 5, LO = 0xFFFF_FFFF, `divzero` and `done` pulse together. The next op shows `divzero` = 0.
- **Control:**
  - `start` asserted during RUN is ignored; HI/LO stay unchanged until the original op's FIX.
  - `mthi` with `wdat` = 0x1234 in IDLE → `hi` = 0x1234 next cycle.
  - `mthi` together with `start` → HI comes from the multiply/divide.
- **Reset:** assert `RST` at RUN iteration 10, asynchronously mid-cycle. Immediately `busy` = 0, `hi` = `lo` = 0, no `done`. After release, a fresh MULTU 6 × 7 gives LO = 42.
